// File: rtl/crossover_sched.sv
// ============================================================================
// Module   : crossover_sched
// Purpose  : Sequences one child-genome crossover job. It reads parent gene
//            pairs, streams them through an external crossover/perturb
//            datapath, and buffers the results in a skid FIFO. The FIFO then
//            drains into the child gene memory under ready/valid handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crossover_sched #(
    parameter int GENE_SZ    = 64,
    parameter int ATTR_SZ    = 8,
    parameter int ADDR_SZ    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    // control side
    input  logic               start,
    input  logic [GENE_SZ-1:0] cfg_word,
    input  logic [ATTR_SZ-1:0] child_id,
    input  logic [ADDR_SZ-1:0] num_genes,
    output logic               busy,
    output logic               done,
    // parent gene memories (1-cycle read latency)
    output logic               rd_en,
    output logic [ADDR_SZ-1:0] rd_addr,
    input  logic [GENE_SZ-1:0] rd_data1,
    input  logic [GENE_SZ-1:0] rd_data2,
    // crossover/perturb datapath
    output logic               dp_setup,
    output logic               dp_bubble,
    output logic               dp_bias,
    output logic [GENE_SZ-1:0] dp_data_in1,
    output logic [GENE_SZ-1:0] dp_data_in2,
    output logic [GENE_SZ-1:0] dp_gene1,
    output logic [GENE_SZ-1:0] dp_gene2,
    input  logic [GENE_SZ-1:0] dp_child_gene,
    // child memory write
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_SZ-1:0] wr_addr,
    output logic [GENE_SZ-1:0] wr_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough for fifo_count plus the three in-flight stages.
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q,    state_d;
    logic [GENE_SZ-1:0] cfg_q,      cfg_d;
    logic [ATTR_SZ-1:0] id_q,       id_d;
    logic [ADDR_SZ-1:0] num_q,      num_d;
    logic               bias_q,     bias_d;
    logic [ADDR_SZ-1:0] rd_idx_q,   rd_idx_d;
    logic [ADDR_SZ-1:0] wr_idx_q,   wr_idx_d;
    // flight_q[k] marks a gene issued k+1 cycles ago; stage 0 is the issue itself.
    logic [2:0]         flight_q,   flight_d;
    logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]   wptr_q,     wptr_d;
    logic [PTR_W-1:0]   rptr_q,     rptr_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               setup_q,    setup_d;
    logic               bubble_q,   bubble_d;
    logic [GENE_SZ-1:0] fifo_mem_q [FIFO_DEPTH];

    logic [CNT_W-1:0]   occupancy;
    logic               issue;
    logic               push;
    logic               pop;

    // Genes committed but not yet written: FIFO contents plus in-flight stages.
    assign occupancy = fifo_count_q + CNT_W'(flight_q[0]) + CNT_W'(flight_q[1])
                     + CNT_W'(flight_q[2]);
    assign issue = (state_q == S_RUN) && (rd_idx_q < num_q) && (occupancy < DEPTH_C);
    assign push  = flight_q[2];
    assign pop   = (fifo_count_q != '0) && wr_ready;

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = issue;
    assign rd_addr     = rd_idx_q;
    assign dp_setup    = setup_q;
    assign dp_bubble   = bubble_q;
    assign dp_bias     = bias_q;
    assign dp_data_in1 = cfg_q;
    assign dp_data_in2 = {{(GENE_SZ-ATTR_SZ){1'b0}}, id_q};
    assign dp_gene1    = rd_data1;
    assign dp_gene2    = rd_data2;
    assign wr_valid    = (fifo_count_q != '0);
    assign wr_addr     = wr_idx_q;
    assign wr_data     = fifo_mem_q[rptr_q];

    // Next-state, counters, FIFO bookkeeping and the registered strobes.
    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        id_d         = id_q;
        num_d        = num_q;
        bias_d       = bias_q;
        rd_idx_d     = rd_idx_q + ADDR_SZ'(issue);
        wr_idx_d     = wr_idx_q + ADDR_SZ'(pop);
        flight_d     = {flight_q[1:0], issue};
        fifo_count_d = fifo_count_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d    = cfg_word;
                    id_d     = child_id;
                    num_d    = num_genes;
                    bias_d   = cfg_word[GENE_SZ-9 -: 8] > cfg_word[GENE_SZ-1 -: 8];
                    rd_idx_d = '0;
                    wr_idx_d = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: state_d = (num_q == '0) ? S_DRAIN : S_RUN;
            S_RUN: begin
                if (issue && ((rd_idx_q + ADDR_SZ'(1)) == num_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((flight_q == 3'b000) && (fifo_count_q == '0) && (wr_idx_q == num_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        setup_d  = (state_d == S_SETUP);
        bubble_d = !issue;
    end

    // All control state; an asserted reset abandons any job in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            id_q         <= '0;
            num_q        <= '0;
            bias_q       <= 1'b0;
            rd_idx_q     <= '0;
            wr_idx_q     <= '0;
            flight_q     <= '0;
            fifo_count_q <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            setup_q      <= 1'b0;
            bubble_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            id_q         <= id_d;
            num_q        <= num_d;
            bias_q       <= bias_d;
            rd_idx_q     <= rd_idx_d;
            wr_idx_q     <= wr_idx_d;
            flight_q     <= flight_d;
            fifo_count_q <= fifo_count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            setup_q      <= setup_d;
            bubble_q     <= bubble_d;
        end
    end

    // Child gene storage; contents are only meaningful below fifo_count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= dp_child_gene;
        end
    end

`ifndef SYNTHESIS
    // The issue throttle guarantees room for every in-flight gene.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_count_q == DEPTH_C)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_crossover_sched.sv
// ============================================================================
// Module   : tb_crossover_sched
// Purpose  : Self-checking bench for crossover_sched with parent memory and
//            datapath models plus a write-side scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crossover_sched;

    localparam int GENE_SZ = 64;
    localparam int ATTR_SZ = 8;
    localparam int ADDR_SZ = 8;
    localparam int FIFO_DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [GENE_SZ-1:0] cfg_word = '0;
    logic [ATTR_SZ-1:0] child_id = '0;
    logic [ADDR_SZ-1:0] num_genes = '0;
    logic               busy, done, rd_en;
    logic [ADDR_SZ-1:0] rd_addr;
    logic [GENE_SZ-1:0] rd_data1 = '0, rd_data2 = '0;
    logic               dp_setup, dp_bubble, dp_bias;
    logic [GENE_SZ-1:0] dp_data_in1, dp_data_in2, dp_gene1, dp_gene2;
    logic [GENE_SZ-1:0] dp_child_gene = '0, dp_p1 = '0;
    logic               wr_valid;
    logic               wr_ready = 1'b0;
    logic [ADDR_SZ-1:0] wr_addr;
    logic [GENE_SZ-1:0] wr_data;

    crossover_sched #(
        .GENE_SZ(GENE_SZ), .ATTR_SZ(ATTR_SZ), .ADDR_SZ(ADDR_SZ), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_word(cfg_word), .child_id(child_id),
        .num_genes(num_genes), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .dp_setup(dp_setup),
        .dp_bubble(dp_bubble), .dp_bias(dp_bias), .dp_data_in1(dp_data_in1),
        .dp_data_in2(dp_data_in2), .dp_gene1(dp_gene1), .dp_gene2(dp_gene2),
        .dp_child_gene(dp_child_gene), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] gene_a(input int i);
        return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
    endfunction
    function automatic logic [63:0] gene_b(input int i);
        return {32'(i) ^ 32'hDEAD_BEEF, 32'(i * 3 + 7)};
    endfunction
    function automatic logic [63:0] child_of(input logic [63:0] a, input logic [63:0] b);
        return (a ^ {b[31:0], b[63:32]}) + 64'd1;
    endfunction

    // Parent memories: one-cycle registered read.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= gene_a(int'(rd_addr));
            rd_data2 <= gene_b(int'(rd_addr));
        end
    end

    // Datapath: two-stage pipeline from gene pair to child gene.
    always @(posedge clk) begin
        dp_p1         <= child_of(dp_gene1, dp_gene2);
        dp_child_gene <= dp_p1;
    end

    int n_checks = 0;
    int n_pass = 0;

    bit                 mon_active = 1'b0;
    int                 mon_cyc, mc, mon_num;
    logic [GENE_SZ-1:0] mon_cfg;
    logic [ATTR_SZ-1:0] mon_id;
    int                 exp_rd, exp_wr, done_cnt, done_cyc;
    int                 first_rd, last_rd, first_wr, last_wr;
    bit                 prev_issue, exp_issue;
    logic [GENE_SZ-1:0] exp_q [$];
    logic [GENE_SZ-1:0] exp_data;

    // Cycle monitor: issue model, bubble model, setup contents and scoreboard.
    always @(negedge clk) begin
        if (mon_active) begin
            mc = mon_cyc;
            mon_cyc++;
            exp_issue = (mc >= 2) && (exp_rd < mon_num) && ((exp_rd - exp_wr) < FIFO_DEPTH);
            n_checks++;
            if (rd_en !== exp_issue) $display("FAIL rd_en cyc=%0d: got %0b want %0b", mc, rd_en, exp_issue);
            else n_pass++;
            n_checks++;
            if (dp_bubble !== !prev_issue) $display("FAIL dp_bubble cyc=%0d: got %0b want %0b", mc, dp_bubble, !prev_issue);
            else n_pass++;
            prev_issue = exp_issue;
            if (mc == 1) begin
                n_checks++;
                if (dp_setup !== 1'b1 || dp_data_in1 !== mon_cfg || dp_data_in2 !== {56'd0, mon_id})
                    $display("FAIL setup: got setup=%0b in1=%h in2=%h want 1 %h %h", dp_setup,
                             dp_data_in1, dp_data_in2, mon_cfg, {56'd0, mon_id});
                else n_pass++;
            end
            if (rd_en) begin
                n_checks++;
                if (rd_addr !== ADDR_SZ'(exp_rd)) $display("FAIL rd_addr: got %0d want %0d", rd_addr, exp_rd);
                else n_pass++;
                exp_q.push_back(child_of(gene_a(exp_rd), gene_b(exp_rd)));
                exp_rd++;
                if (first_rd < 0) first_rd = mc;
                last_rd = mc;
            end
            if (wr_valid && wr_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL spurious_write: got addr %0d want no write", wr_addr);
                end else begin
                    exp_data = exp_q.pop_front();
                    if (wr_addr !== ADDR_SZ'(exp_wr) || wr_data !== exp_data)
                        $display("FAIL write: got addr %0d data %h want addr %0d data %h",
                                 wr_addr, wr_data, exp_wr, exp_data);
                    else n_pass++;
                end
                exp_wr++;
                if (first_wr < 0) first_wr = mc;
                last_wr = mc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = mc;
            end
        end
    end

    task automatic start_job(input int n, input logic [63:0] cfg, input logic [7:0] id);
        @(posedge clk); #1;
        start = 1'b1; cfg_word = cfg; child_id = id; num_genes = ADDR_SZ'(n);
        exp_rd = 0; exp_wr = 0; exp_q.delete(); done_cnt = 0; done_cyc = -1;
        prev_issue = 1'b0; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        mon_num = n; mon_cfg = cfg; mon_id = id; mon_cyc = 0; mon_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (done_cnt == 0) $display("FAIL done_timeout: got no done want done within %0d cycles", budget);
        else n_pass++;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (done_cnt != 1) $display("FAIL done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, rd_en, wr_valid, dp_setup, dp_bubble, dp_bias} !== 7'b0000010)
            $display("FAIL reset_outputs: got %b want 0000010",
                     {busy, done, rd_en, wr_valid, dp_setup, dp_bubble, dp_bias});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dp_bubble !== 1'b1) $display("FAIL idle_outputs: got busy=%0b bubble=%0b want 0 1", busy, dp_bubble);
        else n_pass++;
    endtask

    task automatic test_basic();
        wr_ready = 1'b1;
        start_job(4, 64'h2010_0102_0304_0506, 8'h5A);
        wait_done(60);
        n_checks++;
        if (first_rd != 2 || last_rd != 5) $display("FAIL basic_reads: got cyc %0d..%0d want 2..5", first_rd, last_rd);
        else n_pass++;
        n_checks++;
        if (first_wr != 6 || last_wr != 9 || exp_wr != 4) $display("FAIL basic_writes: got cyc %0d..%0d n=%0d want 6..9 n=4", first_wr, last_wr, exp_wr);
        else n_pass++;
        n_checks++;
        if (done_cyc != 11) $display("FAIL basic_latency: got %0d want 11", done_cyc);
        else n_pass++;
    endtask

    task automatic test_zero();
        wr_ready = 1'b1;
        start_job(0, 64'h0, 8'h01);
        wait_done(20);
        n_checks++;
        if (done_cyc != 3 || exp_rd != 0 || exp_wr != 0) $display("FAIL zero_job: got done_cyc=%0d reads=%0d writes=%0d want 3 0 0", done_cyc, exp_rd, exp_wr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        wr_ready = 1'b0;
        start_job(20, 64'h3030_1234_5678_9ABC, 8'h22);
        repeat (30) @(negedge clk);
        #1;
        n_checks++;
        if (exp_rd != 8) $display("FAIL bp_reads: got %0d want 8", exp_rd);
        else n_pass++;
        n_checks++;
        if (dut.fifo_count_q !== 5'd8 || wr_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL bp_fifo: got count=%0d valid=%0b busy=%0b want 8 1 1", dut.fifo_count_q, wr_valid, busy);
        else n_pass++;
        @(posedge clk); #1;
        wr_ready = 1'b1;
        wait_done(100);
        n_checks++;
        if (exp_wr != 20 || exp_q.size() != 0) $display("FAIL bp_drain: got writes=%0d left=%0d want 20 0", exp_wr, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_toggle();
        int k;
        wr_ready = 1'b1;
        start_job(10, 64'h0F0F_AAAA_5555_0F0F, 8'h77);
        k = 0;
        while (done_cnt == 0 && k < 200) begin
            @(posedge clk); #1;
            wr_ready = ~wr_ready;
            k++;
        end
        n_checks++;
        if (done_cnt != 1 || exp_wr != 10 || exp_q.size() != 0)
            $display("FAIL toggle_job: got done=%0d writes=%0d left=%0d want 1 10 0", done_cnt, exp_wr, exp_q.size());
        else n_pass++;
        wr_ready = 1'b1;
    endtask

    task automatic test_bias();
        wr_ready = 1'b1;
        start_job(6, 64'h1020_0000_0000_0001, 8'h10);
        @(negedge clk); #1;
        n_checks++;
        if (dp_bias !== 1'b1) $display("FAIL bias_lt: got %0b want 1", dp_bias);
        else n_pass++;
        @(posedge clk); #1;
        start = 1'b1; cfg_word = 64'h2010_0000_0000_0002; num_genes = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (dp_bias !== 1'b1) $display("FAIL bias_stable: got %0b want 1", dp_bias);
        else n_pass++;
        wait_done(60);
        n_checks++;
        if (exp_wr != 6 || busy !== 1'b0) $display("FAIL start_ignored: got writes=%0d busy=%0b want 6 0", exp_wr, busy);
        else n_pass++;
        start_job(2, 64'h2010_0000_0000_0003, 8'h11);
        n_checks++;
        if (dp_bias !== 1'b0) $display("FAIL bias_gt: got %0b want 0", dp_bias);
        else n_pass++;
        wait_done(40);
    endtask

    task automatic test_reset_mid();
        int k;
        wr_ready = 1'b1;
        start_job(10, 64'h1020_4444_4444_4444, 8'h99);
        k = 0;
        while (exp_rd != 5 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (exp_rd != 5) $display("FAIL mid_reach: got %0d reads want 5", exp_rd);
        else n_pass++;
        mon_active = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, rd_en, wr_valid, dp_setup, dp_bubble, dp_bias} !== 7'b0000010)
            $display("FAIL mid_reset_outputs: got %b want 0000010",
                     {busy, done, rd_en, wr_valid, dp_setup, dp_bubble, dp_bias});
        else n_pass++;
        n_checks++;
        if (dut.rd_idx_q !== 8'd0 || dut.wr_idx_q !== 8'd0 || dut.fifo_count_q !== 5'd0 || dut.flight_q !== 3'd0)
            $display("FAIL mid_reset_state: got rd=%0d wr=%0d cnt=%0d fl=%b want 0 0 0 000",
                     dut.rd_idx_q, dut.wr_idx_q, dut.fifo_count_q, dut.flight_q);
        else n_pass++;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (wr_valid !== 1'b0) $display("FAIL mid_no_write: got %0b want 0", wr_valid);
            else n_pass++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        start_job(2, 64'h0000_0000_0000_0004, 8'h12);
        wait_done(40);
        n_checks++;
        if (exp_wr != 2 || exp_q.size() != 0) $display("FAIL post_reset_job: got writes=%0d left=%0d want 2 0", exp_wr, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_toggle();
        test_bias();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/crossover_sched.md
CROSSOVER_SCHED -- requirements
Module: crossover_sched

Interface
REQ-001 SHALL have parameters: GENE_SZ 64 (gene width); ATTR_SZ 8 (attribute/ID width); ADDR_SZ 8 (gene index width); FIFO_DEPTH 8 (child skid buffer entries).
REQ-002 SHALL have reset rst (asynchronous, active-high) and clock clk.
REQ-003 Ports, control side:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  launch one child-genome job
- cfg_word  in  GENE_SZ  {p1_fit, p2_fit, 6 mutation probabilities}
- child_id  in  ATTR_SZ  child genome ID
- num_genes  in  ADDR_SZ  gene pairs in the job
- busy  out  1  job active
- done  out  1  one-cycle completion pulse
REQ-004 Ports, parent gene memories (1-cycle read latency):
- rd_en  out  1  read strobe
- rd_addr  out  ADDR_SZ  gene index
- rd_data1, rd_data2  in  GENE_SZ  parent genes
REQ-005 Ports, crossover/perturb datapath:
- dp_setup  out  1  setup strobe
- dp_bubble  out  1  bubble strobe
- dp_bias  out  1  bias_ext
- dp_data_in1, dp_data_in2  out  GENE_SZ  setup words
- dp_gene1, dp_gene2  out  GENE_SZ  gene pair
- dp_child_gene  in  GENE_SZ  datapath result
REQ-006 Ports, child memory write:
- wr_valid  out  1  write request
- wr_ready  in  1  sink accepts
- wr_addr  out  ADDR_SZ  child gene index
- wr_data  out  GENE_SZ  child gene

Function
REQ-007 FSM states: IDLE, SETUP, RUN, DRAIN, DONE; start is sampled only in IDLE and ignored otherwise.
REQ-008 IDLE + start: capture cfg_word, child_id, num_genes -> SETUP.
REQ-009 SETUP is one cycle with dp_setup=1, dp_data_in1=captured cfg_word, dp_data_in2={zeros, child_id}; -> RUN, or -> DRAIN if num_genes==0.
REQ-010 dp_bias SHALL be registered (p2_fit > p1_fit), where p1_fit=cfg_word[63:56] and p2_fit=cfg_word[55:48], unsigned; it is updated at capture and stable for the whole job.
REQ-011 RUN issue rule: issue (rd_en=1, rd_addr=rd_idx, rd_idx++) iff rd_idx<num_genes and fifo_count+inflight<FIFO_DEPTH.
REQ-012 dp_gene1/2 SHALL be rd_data1/2 driven combinationally; dp_bubble=1 in every cycle whose previous cycle had no issue, including SETUP+1.
REQ-013 inflight SHALL be a 4-stage valid shift register, with stage 0 being the issue cycle; the stage-3 output pushes dp_child_gene into the FIFO the following cycle, so issue-to-push latency is 4 cycles.
REQ-014 RUN -> DRAIN when the last index is issued; DRAIN -> DONE when inflight==0, fifo empty, and wr_idx==num_genes.
REQ-015 FIFO: wr_valid = !empty and wr_data = head entry; pop and wr_idx++ on wr_valid&wr_ready; push and pop in the same cycle keep the count unchanged.
REQ-016 The FIFO never overflows by construction of REQ-011; a push while full is a design error and is flagged by an assertion.
REQ-017 wr_addr SHALL equal wr_idx, with wr_idx=0 at job start; the write order equals the issue order.
REQ-018 DONE: done=1 for exactly one cycle -> IDLE; busy=1 in SETUP, RUN, DRAIN, DONE.
REQ-019 With wr_ready held 1, throughput SHALL be one gene per cycle with no bubbles after the first.
REQ-020 dp_setup and dp_bubble SHALL be 0 in IDLE except that dp_bubble=1; dp_gene and dp_data outputs are don't-care when unused.

Reset
REQ-021 On rst, the FSM goes to IDLE; busy, done, rd_en, wr_valid, and dp_setup are 0; dp_bubble is 1; rd_idx, wr_idx, and fifo_count are 0; inflight is cleared; captured registers and dp_bias are 0.
REQ-022 rst asserted mid-job SHALL abandon the job with no further writes; the next start after reset runs a fresh job.

Verification
REQ-023 Each of the following directed scenarios SHALL be covered:
- start, num_genes=4, wr_ready=1: setup 1 cycle; rd_addr 0..3 on consecutive cycles; wr_valid at addresses 0..3 on 4 consecutive cycles; done once; total 11 cycles start->done.
- num_genes=0: SETUP -> DRAIN -> DONE; no rd_en; no wr_valid; done 3 cycles after start.
- num_genes=20, wr_ready=0 throughout: issue stops after exactly 8 reads; fifo_count=8; no overflow; wr_ready then high: all 20 written in order 0..19.
- wr_ready toggling 1/0 every cycle, num_genes=10: the wr_data sequence matches the reference model; dp_bubble=1 exactly in no-issue cycles.
- cfg_word[63:56]=0x10, [55:48]=0x20: dp_bias=1; swapped: dp_bias=0; start while busy is ignored.
- rst pulse mid-RUN at rd_idx=5: all outputs take REQ-021 values; a new job with num_genes=2 completes normally.
